// File: rtl/cb_filter_pkg.sv
// Shared types for the counting bloom filter and its tracker.
//   tracker_state_e : tracker control state (RUN / FLUSH)
//   CbDefInpWidth   : default width of the tracked data
//   CbDefDepth      : default number of outstanding items
package cb_filter_pkg;

   localparam int CbDefInpWidth = 32;
   localparam int CbDefDepth    = 8;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } tracker_state_e;

endpackage : cb_filter_pkg

// File: rtl/cb_tracker_store.sv
// Circular buffer holding the data of every request whose filter increment
// has not yet been undone. Tracks read/write pointers and occupancy.
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   push_i, push_data_i: write one item at the write pointer
//   pop_i, pop_data_o  : oldest item (valid while !empty_o); pop_i removes it
//   usage_o            : items currently held
//   empty_o, full_o    : occupancy flags
// The caller never pushes when full or pops when empty; a simultaneous
// push and pop leaves the count unchanged while both pointers advance.
module cb_tracker_store
   import cb_filter_pkg::*;
#(
   parameter int InpWidth = CbDefInpWidth,
   parameter int Depth    = CbDefDepth
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic [InpWidth-1:0]          push_data_i,
   input  logic                         pop_i,
   output logic [InpWidth-1:0]          pop_data_o,
   output logic [$clog2(Depth+1)-1:0]   usage_o,
   output logic                         empty_o,
   output logic                         full_o
);

   localparam int PtrWidth = $clog2(Depth);
   localparam int CntWidth = $clog2(Depth+1);

   logic [InpWidth-1:0] mem_q [Depth];
   logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;

   // Depth is a power of two, so pointer wrap is the natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + PtrWidth'(1);
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + PtrWidth'(1);
      end
      if (push_i && !pop_i) begin
         cnt_d = cnt_q + CntWidth'(1);
      end else if (pop_i && !push_i) begin
         cnt_d = cnt_q - CntWidth'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Buffer contents need no reset: nothing is read until it was written.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign pop_data_o = mem_q[rd_ptr_q];
   assign usage_o    = cnt_q;
   assign empty_o    = (cnt_q == '0);
   assign full_o     = (cnt_q == CntWidth'(Depth));

endmodule : cb_tracker_store

// File: rtl/cb_filter_tracker.sv
// Drives the incr/decr side of a counting bloom filter for an in-order
// transaction stream. Each accepted request is remembered and increments the
// filter; each response pops the oldest item and decrements it, so only data
// that was inserted is ever removed. A flush drains every outstanding item.
// Ports:
//   clk_i, rst_i                    : clock, asynchronous active-high reset
//   req_valid_i/req_ready_o/req_data_i : request port (data to insert)
//   rsp_valid_i/rsp_ready_o         : completion of the oldest request
//   flush_i, flush_busy_o           : flush pulse and busy indication
//   incr_*_o, decr_*_o              : registered filter update outputs
//   filter_full_i                   : filter saturation flag
//   usage_o, empty_o, full_o        : occupancy
//   error_o                         : sticky protocol error
//
// state | meaning
// ------+----------------------------------------------------------
// RUN   | normal operation, requests and responses accepted
// FLUSH | popping one item per cycle into decr, both readies low
module cb_filter_tracker
   import cb_filter_pkg::*;
#(
   parameter int InpWidth = CbDefInpWidth,
   parameter int Depth    = CbDefDepth
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic [InpWidth-1:0]          req_data_i,
   input  logic                         rsp_valid_i,
   output logic                         rsp_ready_o,
   input  logic                         flush_i,
   output logic                         flush_busy_o,
   output logic [InpWidth-1:0]          incr_data_o,
   output logic                         incr_valid_o,
   output logic [InpWidth-1:0]          decr_data_o,
   output logic                         decr_valid_o,
   input  logic                         filter_full_i,
   output logic [$clog2(Depth+1)-1:0]   usage_o,
   output logic                         empty_o,
   output logic                         full_o,
   output logic                         error_o
);

   localparam int CntWidth = $clog2(Depth+1);

   tracker_state_e      state_q;
   logic [InpWidth-1:0] incr_data_q;
   logic                incr_valid_q;
   logic [InpWidth-1:0] decr_data_q;
   logic                decr_valid_q;
   logic                error_q;

   logic                req_hs;
   logic                rsp_hs;
   logic                flush_pop;
   logic                pop;
   logic                last_pop;
   logic                err_set;
   logic [InpWidth-1:0] pop_data;
   logic [CntWidth-1:0] usage;
   logic                empty;
   logic                full;

   cb_tracker_store #(
      .InpWidth (InpWidth),
      .Depth    (Depth)
   ) u_store (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (req_hs),
      .push_data_i (req_data_i),
      .pop_i       (pop),
      .pop_data_o  (pop_data),
      .usage_o     (usage),
      .empty_o     (empty),
      .full_o      (full)
   );

   // Readies depend only on state and occupancy, never on their own valid.
   assign req_ready_o = (state_q == RUN) && !full && !filter_full_i;
   assign rsp_ready_o = (state_q == RUN) && !empty;

   assign req_hs    = req_valid_i && req_ready_o;
   assign rsp_hs    = rsp_valid_i && rsp_ready_o;
   assign flush_pop = (state_q == FLUSH) && !empty;
   assign pop       = rsp_hs || flush_pop;
   // Last pop of a flush: no pushes happen in FLUSH, so count 1 -> 0.
   assign last_pop  = flush_pop && (usage == CntWidth'(1));
   assign err_set   = (state_q == RUN) && empty && (rsp_valid_i || filter_full_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= RUN;
         incr_data_q  <= '0;
         incr_valid_q <= 1'b0;
         decr_data_q  <= '0;
         decr_valid_q <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               // A flush racing with a response that empties the buffer would
               // leave nothing to drain, so only enter FLUSH with items left.
               if (flush_i && !empty && !(rsp_hs && !req_hs && usage == CntWidth'(1))) begin
                  state_q <= FLUSH;
               end
            end
            FLUSH: begin
               if (last_pop || empty) begin
                  state_q <= RUN;
               end
            end
            default: state_q <= RUN;
         endcase

         incr_valid_q <= req_hs;
         if (req_hs) begin
            incr_data_q <= req_data_i;
         end

         decr_valid_q <= pop;
         if (pop) begin
            decr_data_q <= pop_data;
         end

         if (err_set) begin
            error_q <= 1'b1;
         end
      end
   end

   assign flush_busy_o = (state_q == FLUSH);
   assign incr_data_o  = incr_data_q;
   assign incr_valid_o = incr_valid_q;
   assign decr_data_o  = decr_data_q;
   assign decr_valid_o = decr_valid_q;
   assign usage_o      = usage;
   assign empty_o      = empty;
   assign full_o       = full;
   assign error_o      = error_q;

endmodule : cb_filter_tracker
